// File: rtl/sram_fifo_1p_ctrl.sv
// Valid/ready FIFO front-end for a single-port SRAM, with a prefetch buffer that hides ReadLatency.
// Optional per-word error tracking is enabled with `define I3C_SRAM_FIFO_RERROR_EN.
module sram_fifo_1p_ctrl #(
  parameter int  Depth       = 512,
  parameter int  Width       = 32,
  parameter int  ReadLatency = 1,
  localparam int OutBufDepth = ReadLatency + 1,
  localparam int Aw          = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int Dw          = $clog2(Depth + OutBufDepth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic             rerr_o,
  output logic             err_o,
  output logic [Dw-1:0]    depth_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i,
  input  logic             ram_rvalid_i,
  input  logic [1:0]       ram_rerror_i
);

  localparam int            Ow       = $clog2(OutBufDepth);
  localparam logic [Dw-1:0] DepthC   = Dw'(Depth);
  localparam logic [Dw-1:0] ObDepthC = Dw'(OutBufDepth);
  localparam logic [Aw-1:0] LastPtr  = Aw'(Depth - 1);

  logic             alive_q;
  logic [Aw-1:0]    wptr_q, rptr_q;
  logic [Dw-1:0]    ram_cnt_q, inflight_q, ob_cnt_q, discard_q, depth_q;
  logic [Dw-1:0]    ram_cnt_d, inflight_d, ob_cnt_d, discard_d;
  logic [Dw-1:0]    pend;
  logic             starve, read_ok, space;
  logic             do_rd, do_wr, push, drop, pop;
  logic [Ow-1:0]    ob_widx;
  logic [Width-1:0] ob_data_q [OutBufDepth];

  assign pend    = ob_cnt_q + inflight_q;
  assign starve  = (pend == '0) && (ram_cnt_q != '0);
  assign read_ok = (ram_cnt_q != '0) && (pend < ObDepthC);
  assign space   = ram_cnt_q < DepthC;
  assign pop     = (ob_cnt_q != '0) && rready_i;
  assign drop    = ram_rvalid_i && (discard_q != '0);
  assign push    = ram_rvalid_i && (discard_q == '0);
  assign ob_widx = Ow'(ob_cnt_q - Dw'(pop));

  always_comb begin
    do_rd = 1'b0;
    do_wr = 1'b0;
    if (alive_q && !clr_i) begin
      if (starve)                 do_rd = 1'b1;
      else if (wvalid_i && space) do_wr = 1'b1;
      else if (read_ok)           do_rd = 1'b1;
    end
  end

  always_comb begin
    ram_cnt_d  = ram_cnt_q;
    inflight_d = inflight_q;
    ob_cnt_d   = ob_cnt_q;
    discard_d  = discard_q;
    if (clr_i) begin
      ram_cnt_d  = '0;
      inflight_d = '0;
      ob_cnt_d   = '0;
      // every response still owed by the RAM must be swallowed, including one landing now
      discard_d  = inflight_q + discard_q - Dw'(ram_rvalid_i);
    end else begin
      ram_cnt_d  = ram_cnt_q + Dw'(do_wr) - Dw'(do_rd);
      inflight_d = inflight_q + Dw'(do_rd) - Dw'(push);
      ob_cnt_d   = ob_cnt_q + Dw'(push) - Dw'(pop);
      discard_d  = discard_q - Dw'(drop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alive_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= '0;
      ob_cnt_q   <= '0;
      discard_q  <= '0;
      depth_q    <= '0;
    end else begin
      alive_q    <= 1'b1;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      discard_q  <= discard_d;
      depth_q    <= ram_cnt_d + inflight_d + ob_cnt_d;
      if (clr_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (do_wr) wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + Aw'(1);
        if (do_rd) rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + Aw'(1);
      end
    end
  end

  // Shift-register prefetch buffer: entry 0 is always the head
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < OutBufDepth; i++) ob_data_q[i] <= '0;
    end else if (!clr_i) begin
      if (pop) begin
        for (int i = 0; i < OutBufDepth - 1; i++) ob_data_q[i] <= ob_data_q[i+1];
      end
      if (push) ob_data_q[ob_widx] <= ram_rdata_i;
    end
  end

`ifdef I3C_SRAM_FIFO_RERROR_EN
  logic [OutBufDepth-1:0] ob_err_q;
  logic                   err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ob_err_q <= '0;
      err_q    <= 1'b0;
    end else if (!clr_i) begin
      if (push && (ram_rerror_i != 2'b00)) err_q <= 1'b1;
      if (pop)  ob_err_q <= ob_err_q >> 1;
      if (push) ob_err_q[ob_widx] <= ram_rerror_i[1];
    end
  end

  assign rerr_o = rvalid_o && ob_err_q[0];
  assign err_o  = err_q;
`else
  logic unused_rerror;
  assign unused_rerror = ^ram_rerror_i;
  assign rerr_o        = 1'b0;
  assign err_o         = 1'b0;
`endif

  assign wready_o    = alive_q && space && !starve && !clr_i;
  assign rvalid_o    = ob_cnt_q != '0;
  assign rdata_o     = ob_data_q[0];
  assign depth_o     = depth_q;
  assign ram_req_o   = do_rd || do_wr;
  assign ram_write_o = do_wr;
  assign ram_addr_o  = do_wr ? wptr_q : rptr_q;
  assign ram_wdata_o = do_wr ? wdata_i : '0;
  assign ram_wmask_o = {Width{alive_q}};

  a_no_orphan_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ram_rvalid_i |-> ((inflight_q + discard_q) != '0));
  a_no_ob_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push && !clr_i) |-> ((ob_cnt_q < ObDepthC) || pop));

endmodule

// File: doc/sram_fifo_1p_ctrl.md
Name: sram_fifo_1p_ctrl

Overview:
- FIFO controller that sits directly upstream and downstream of the single-port SRAM wrapper.
- Converts a valid/ready write stream and a valid/ready read stream into single-port RAM requests.
- Consumes the RAM read responses (rdata, rvalid, rerror) into a small output prefetch buffer.
- Provides a large RAM-backed FIFO, e.g. I3C TX/RX queues, while hiding configurable RAM read latency.

Parameters:
- Depth, 512: RAM words; any value >= 2, not required to be a power of two.
- Width, 32: data width.
- ReadLatency, 1: RAM req-to-rvalid latency in cycles, 1..3; must match the RAM pipeline configuration.
- OutBufDepth, ReadLatency+1 (localparam): prefetch buffer entries.
- Aw, vbits(Depth) (localparam): RAM address width.
- Dw, vbits(Depth+OutBufDepth+1) (localparam): occupancy width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous flush.
- wvalid_i  in  1  write data valid.
- wready_o  out  1  write accepted when wvalid_i && wready_o.
- wdata_i  in  Width  write data.
- rvalid_o  out  1  read data available.
- rready_i  in  1  consumer pops when rvalid_o && rready_i.
- rdata_o  out  Width  head-of-FIFO data.
- rerr_o  out  1  head word carries an uncorrectable RAM error.
- err_o  out  1  sticky RAM error flag.
- depth_o  out  Dw  total words held.
- ram_req_o  out  1  RAM request.
- ram_write_o  out  1  RAM write enable.
- ram_addr_o  out  Aw  RAM address.
- ram_wdata_o  out  Width  RAM write data.
- ram_wmask_o  out  Width  RAM write mask; always all ones.
- ram_rdata_i  in  Width  RAM read data.
- ram_rvalid_i  in  1  RAM read response valid.
- ram_rerror_i  in  2  RAM error response; bit1 uncorrectable, bit0 correctable.

Behaviour:
- Reset: all outputs 0 (wready_o is 0 during reset only); wptr, rptr, ram_cnt, inflight, ob_cnt, discard all 0.
- State:
  - ram_cnt: words resident in RAM.
  - inflight: reads issued but not yet returned.
  - ob_cnt: entries in the prefetch buffer (register FIFO, OutBufDepth deep).
- One RAM operation per cycle; arbitration is combinational each cycle.
- starve = (ob_cnt + inflight == 0) && (ram_cnt > 0).
- read_ok = (ram_cnt > 0) && (ob_cnt + inflight < OutBufDepth).
- Priority:
  - starve → read.
  - else wvalid_i && ram_cnt < Depth → write.
  - else read_ok → read.
  - else idle.
- wready_o = (ram_cnt < Depth) && !starve && !clr_i. It has no combinational dependency on wvalid_i.
- Write: ram_req_o=1, ram_write_o=1, ram_addr_o=wptr, ram_wdata_o=wdata_i. Then wptr advances and ram_cnt increments.
- Read: ram_req_o=1, ram_write_o=0, ram_addr_o=rptr. Then rptr advances, ram_cnt decrements and inflight increments.
- Pointers wrap from Depth-1 to 0.
- ram_rvalid_i:
  - pushes {ram_rdata_i, ram_rerror_i[1]} into the prefetch buffer and decrements inflight;
  - room is guaranteed by read_ok;
  - SVA: ram_rvalid_i implies inflight + discard > 0.
- Pop: rvalid_o = (ob_cnt > 0). rdata_o/rerr_o show the buffer head, registered. A pop and a push in the same cycle keep ob_cnt unchanged.
- depth_o = ram_cnt + inflight + ob_cnt, registered, updated the cycle after each event. Maximum value is Depth + OutBufDepth.
- Latency: a write accepted in cycle N (empty FIFO) → read issued in N+1 → rvalid_o high in N+2+ReadLatency.
- Full: ram_cnt == Depth → wready_o=0. A pop does not immediately free a RAM slot; it only enables a further prefetch read.
- Simultaneous wvalid and starve: the read wins and the write stalls one cycle.
- clr_i, taking priority over all other events in its cycle:
  - zeroes ptrs, ram_cnt, ob_cnt and inflight;
  - sets discard = inflight;
  - responses arriving while discard > 0 are dropped and decrement discard;
  - no RAM request is issued in the clr_i cycle;
  - err_o is not cleared.
- Reset mid-operation: asynchronous clear of all state. Responses arriving after reset deassertion are outside the contract (the RAM shares reset).

Optional Feature:
- Macro I3C_SRAM_FIFO_RERROR_EN.
- Defined:
  - ram_rerror_i[1] is stored per prefetch entry and presented on rerr_o with the word.
  - err_o is set on any response with ram_rerror_i != 0, excluding discarded responses, and stays set until reset.
- Undefined:
  - the error bit is not stored;
  - rerr_o and err_o are tied to 0;
  - ram_rerror_i is unused (reduction-XOR into an unused signal).

Test Plan:
- ReadLatency=1, single write 0xA5A5_0001 at cycle 0, rready_i=1 → rvalid_o=1 at cycle 3 with rdata_o=0xA5A5_0001; depth_o goes 0→1→0.
- Depth=4, OutBufDepth=2, rready_i=0, 8 writes offered:
  - 6 accepted; the first 2 words migrate to the prefetch buffer;
  - afterwards ram_cnt=4, wready_o=0, depth_o=6.
  - Then pop all 6 → data in order, and the pointers wrap correctly.
- Continuous wvalid_i and rready_i, ReadLatency=3, 200 random words → output order identical to input, no overflow SVA fires, each starve cycle stalls wready_o.
- Issue 2 reads with ReadLatency=3, pulse clr_i the next cycle → both late responses dropped, rvalid_o stays 0, depth_o=0; a new write 0x55 then reads back 0x55.
- With I3C_SRAM_FIFO_RERROR_EN defined, force ram_rerror_i=2'b10 on the second response → rerr_o=1 only with the second word, err_o=1 and sticky.
- Without the macro, the same stimulus → rerr_o=0, err_o=0.
- Assert rst_ni low mid-stream with 3 words held → all outputs 0 asynchronously; after release depth_o=0 and wready_o=1.
